// File: rtl/fir_ch_sched.sv
// fir_ch_sched: two-channel round-robin feeder for a shared FIR core, tagging each sample with its source channel.
// Optional FIR_SCHED_CNT_EN adds per-channel result counters cnt0/cnt1.
module fir_ch_sched #(
  parameter int TAG_DEPTH = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic [15:0] s0_tdata,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  input  logic [15:0] s1_tdata,
  output logic        f_s_tvalid,
  input  logic        f_s_tready,
  output logic [15:0] f_s_tdata,
  input  logic        f_m_tvalid,
  input  logic [33:0] f_m_tdata,
  output logic        m_tvalid,
  output logic [33:0] m_tdata,
  output logic        m_tuser,
  output logic        err_underflow
`ifdef FIR_SCHED_CNT_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
`endif
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, pend_q, pend_d;
  logic [15:0] fsd_q, fsd_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mv_q, mv_d, mu_q, mu_d, err_q, err_d;
  logic [33:0] md_q, md_d;
  logic tag_mem_q [TAG_DEPTH];
  logic full, empty, acc, g1, take, push, pop;
  always_comb begin
    full    = cnt_q == CW'(TAG_DEPTH);
    empty   = cnt_q == '0;
    acc     = aresetn && state_q == IDLE && !full;
    g1      = s1_tvalid && (!s0_tvalid || !last_q);
    take    = acc && (g1 ? s1_tvalid : s0_tvalid);
    push    = state_q == LOAD && f_s_tready;
    pop     = f_m_tvalid && !empty;
    state_d = take ? LOAD : push ? IDLE : state_q;
    last_d  = take ? g1 : last_q;
    pend_d  = take ? g1 : pend_q;
    fsd_d   = take ? (g1 ? s1_tdata : s0_tdata) : fsd_q;
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    mv_d    = f_m_tvalid;
    md_d    = f_m_tvalid ? f_m_tdata : md_q;
    mu_d    = f_m_tvalid ? (pop && tag_mem_q[rd_q]) : mu_q;
    err_d   = err_q || (f_m_tvalid && empty);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      pend_q  <= 1'b0;
      fsd_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      mv_q    <= 1'b0;
      md_q    <= '0;
      mu_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      fsd_q   <= fsd_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      mv_q    <= mv_d;
      md_q    <= md_d;
      mu_q    <= mu_d;
      err_q   <= err_d;
    end
  end
  // Tag storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge aclk) begin
    if (push) tag_mem_q[wr_q] <= pend_q;
  end
  assign s0_tready     = acc && !g1;
  assign s1_tready     = acc && g1;
  assign f_s_tvalid    = state_q == LOAD;
  assign f_s_tdata     = fsd_q;
  assign m_tvalid      = mv_q;
  assign m_tdata       = md_q;
  assign m_tuser       = mu_q;
  assign err_underflow = err_q;
`ifdef FIR_SCHED_CNT_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  always_comb begin
    cnt0_d = cnt0_q + 16'(pop && !tag_mem_q[rd_q]);
    cnt1_d = cnt1_q + 16'(pop && tag_mem_q[rd_q]);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_fir_ch_sched.sv
// tb_fir_ch_sched: randomized scoreboard bench for fir_ch_sched with a queue-based reference model.
module tb_fir_ch_sched;
  localparam int DEPTH = 16;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic s0_tvalid = 0, s0_tready, s1_tvalid = 0, s1_tready;
  logic [15:0] s0_tdata = 0, s1_tdata = 0, f_s_tdata;
  logic f_s_tvalid, f_s_tready = 0, f_m_tvalid = 0;
  logic [33:0] f_m_tdata = 0, m_tdata;
  logic m_tvalid, m_tuser, err_underflow;
`ifdef FIR_SCHED_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif
  fir_ch_sched #(.TAG_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata),
    .f_s_tvalid(f_s_tvalid), .f_s_tready(f_s_tready), .f_s_tdata(f_s_tdata),
    .f_m_tvalid(f_m_tvalid), .f_m_tdata(f_m_tdata),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .err_underflow(err_underflow)
`ifdef FIR_SCHED_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );
  always #5 aclk = ~aclk;
  typedef struct packed {logic ch; logic [33:0] d;} ent_t;
  ent_t fir_pipe[$];
  ent_t exp_out[$];
  ent_t m_pend;
  bit m_busy, m_last = 1, m_err;
  int m_cnt[2];
  bit hold[2];
  logic [15:0] sdat[2];
  int p_v0, p_v1, p_fsr, p_fm;
  bit force_uf, do_rst;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge aclk) begin
    ent_t e;
    if (m_tvalid === 1'b1) begin
      if (exp_out.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_m_tvalid: got m_tdata %h with no result expected", m_tdata);
      end else begin
        e = exp_out.pop_front();
        chk("m_tdata", m_tdata, e.d);
        chk("m_tuser", m_tuser, e.ch);
      end
    end
  end
  task automatic cyc();
    bit acc, g1, v0, v1;
    ent_t e;
    @(posedge aclk);
    #2;
    if (do_rst) begin
      aresetn = 0; s0_tvalid = 0; s1_tvalid = 0; f_m_tvalid = 0; hold = '{0, 0};
      #1;
      chk("rst_s0_tready", s0_tready, 0);
      chk("rst_s1_tready", s1_tready, 0);
      chk("rst_f_s_tvalid", f_s_tvalid, 0);
      chk("rst_f_s_tdata", f_s_tdata, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_err", err_underflow, 0);
      fir_pipe.delete(); exp_out.delete();
      m_busy = 0; m_last = 1; m_err = 0; m_cnt = '{0, 0};
      return;
    end
    aresetn = 1;
    if (!hold[0] && $urandom_range(99) < p_v0) begin hold[0] = 1; sdat[0] = 16'($urandom); end
    if (!hold[1] && $urandom_range(99) < p_v1) begin hold[1] = 1; sdat[1] = 16'($urandom); end
    s0_tvalid = hold[0]; s0_tdata = hold[0] ? sdat[0] : 16'($urandom);
    s1_tvalid = hold[1]; s1_tdata = hold[1] ? sdat[1] : 16'($urandom);
    f_s_tready = $urandom_range(99) < p_fsr;
    f_m_tvalid = force_uf || (fir_pipe.size() > 0 && $urandom_range(99) < p_fm);
    f_m_tdata = 34'({$urandom(), $urandom()});
    #1;
    chk("err_underflow", err_underflow, m_err);
    chk("f_s_tvalid", f_s_tvalid, m_busy);
    if (m_busy) chk("f_s_tdata", f_s_tdata, m_pend.d);
    v0 = hold[0]; v1 = hold[1];
    acc = !m_busy && fir_pipe.size() < DEPTH;
    g1 = v1 && (!v0 || !m_last);
    if (v0 || v1) begin
      chk("s0_tready", s0_tready, acc && !g1);
      chk("s1_tready", s1_tready, acc && g1);
    end
    if (f_m_tvalid) begin
      if (fir_pipe.size() > 0) begin
        e = fir_pipe.pop_front();
        m_cnt[e.ch]++;
      end else begin
        e.ch = 0;
        m_err = 1;
      end
      e.d = f_m_tdata;
      exp_out.push_back(e);
    end
    if (m_busy && f_s_tready) begin
      fir_pipe.push_back(m_pend);
      m_busy = 0;
    end else if (acc && (v0 || v1)) begin
      m_pend.ch = g1;
      m_pend.d = {18'b0, sdat[g1]};
      m_last = g1;
      m_busy = 1;
      hold[g1] = 0;
    end
  endtask
  task automatic phase(input int a, input int b, input int c, input int d, input int n);
    p_v0 = a; p_v1 = b; p_fsr = c; p_fm = d;
    repeat (n) cyc();
  endtask
  initial begin
    do_rst = 1;
    repeat (3) cyc();
    do_rst = 0;
    phase(100, 100, 100, 70, 60);
    phase(0, 0, 100, 100, 20);
    phase(100, 0, 100, 50, 40);
    phase(70, 70, 30, 40, 200);
    phase(100, 100, 100, 0, 50);
    phase(100, 100, 100, 100, 6);
    phase(50, 50, 50, 50, 300);
    phase(0, 0, 100, 100, 60);
    force_uf = 1;
    cyc();
    force_uf = 0;
    phase(30, 30, 60, 50, 40);
    phase(100, 100, 100, 100, 10);
    phase(100, 100, 0, 0, 4);
    do_rst = 1;
    repeat (2) cyc();
    do_rst = 0;
    phase(0, 100, 100, 0, 6);
    phase(0, 0, 100, 100, 30);
    phase(0, 0, 100, 100, 3);
`ifdef FIR_SCHED_CNT_EN
    chk("cnt0", cnt0, 16'(m_cnt[0]));
    chk("cnt1", cnt1, 16'(m_cnt[1]));
`endif
    chk("results_outstanding", exp_out.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
